// File: rtl/sram_write_monitor_pkg.sv
// rtl/sram_write_monitor_pkg.sv - shared types, constants and CRC helper for the SRAM write monitor
package sram_mon_pkg;

  typedef enum logic [2:0] {
    S_MON_IDLE,
    S_MON_CLEAR,
    S_MON_MONITOR,
    S_MON_SWEEP,
    S_MON_DONE
  } mon_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One CRC-16-CCITT step over a 16-bit word, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data16);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data16[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                   c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/write_bitmap_ram.sv
// rtl/write_bitmap_ram.sv - 1-bit simple dual-port bitmap with registered read (read returns old data on collision)
module write_bitmap_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sram_write_monitor.sv
// rtl/sram_write_monitor.sv - snoops SRAM writes, marks a region bitmap, counts stray/repeat/unwritten words, CRCs the data
module sram_write_monitor
  import sram_mon_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int REGION_LO = 146944,
  parameter int REGION_HI = 262143,
  parameter int CNT_W     = 18
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic              start,
  input  logic              finish,
  input  logic              SRAM_we_n,
  input  logic [ADDR_W-1:0] SRAM_address,
  input  logic [DATA_W-1:0] SRAM_write_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  oor_count,
  output logic [CNT_W-1:0]  multi_count,
  output logic [CNT_W-1:0]  unwritten_count,
  output logic [ADDR_W-1:0] first_multi_addr,
  output logic [15:0]       signature
);

  localparam int DEPTH  = REGION_HI - REGION_LO + 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_SW = $clog2(DEPTH + 2);
  localparam logic [ADDR_W-1:0] LO_A = ADDR_W'(REGION_LO);

  mon_state_t        state_q, state_nx;
  logic [CNT_SW-1:0] cnt;
  logic              drain;
  logic              s1_valid, s2_valid, sw_rd_q;
  logic [IDX_W-1:0]  s1_idx, s2_idx;
  logic [ADDR_W-1:0] s1_addr;

  logic              in_region, write_ok, seen;
  logic [IDX_W-1:0]  idx;
  logic [15:0]       sig_nx;
  logic              ram_wr_en, ram_wr_data, ram_rd_en, ram_rd_data;
  logic [IDX_W-1:0]  ram_wr_addr, ram_rd_addr;

  assign in_region = (32'(SRAM_address) >= 32'(REGION_LO)) && (32'(SRAM_address) <= 32'(REGION_HI));
  assign idx       = IDX_W'(SRAM_address - LO_A);
  assign write_ok  = (state_q == S_MON_MONITOR) && !finish && !drain && !SRAM_we_n;
  // The previous stage-2 write lands in the same edge as our read, so the read sees stale data.
  assign seen      = ram_rd_data || (s2_valid && (s2_idx == s1_idx));
  assign busy      = (state_q == S_MON_CLEAR) || (state_q == S_MON_SWEEP);
  assign done      = (state_q == S_MON_DONE);

  always_comb begin
    sig_nx = signature;
    for (int s = DATA_W / 16 - 1; s >= 0; s--)
      sig_nx = crc16_step(sig_nx, SRAM_write_data[s*16 +: 16]);
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_MON_IDLE:    if (start) state_nx = S_MON_CLEAR;
      S_MON_CLEAR:   if (cnt == CNT_SW'(DEPTH - 1)) state_nx = S_MON_MONITOR;
      S_MON_MONITOR: if ((finish || drain) && !s1_valid) state_nx = S_MON_SWEEP;
      S_MON_SWEEP:   if (cnt == CNT_SW'(DEPTH + 1)) state_nx = S_MON_DONE;
      S_MON_DONE:    if (start) state_nx = S_MON_CLEAR;
      default:       state_nx = S_MON_IDLE;
    endcase
  end

  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = 1'b0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    case (state_q)
      S_MON_CLEAR: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = cnt[IDX_W-1:0];
      end
      S_MON_MONITOR: begin
        ram_wr_en   = s1_valid;
        ram_wr_addr = s1_idx;
        ram_wr_data = 1'b1;
        ram_rd_en   = write_ok && in_region;
        ram_rd_addr = idx;
      end
      S_MON_SWEEP: begin
        ram_rd_en   = (cnt < CNT_SW'(DEPTH));
        ram_rd_addr = cnt[IDX_W-1:0];
        ram_wr_en   = ram_rd_en;
        ram_wr_addr = cnt[IDX_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q          <= S_MON_IDLE;
      cnt              <= '0;
      drain            <= 1'b0;
      s1_valid         <= 1'b0;
      s1_idx           <= '0;
      s1_addr          <= '0;
      s2_valid         <= 1'b0;
      s2_idx           <= '0;
      sw_rd_q          <= 1'b0;
      oor_count        <= '0;
      multi_count      <= '0;
      unwritten_count  <= '0;
      first_multi_addr <= '0;
      signature        <= CRC_INIT;
    end else begin
      state_q  <= state_nx;
      cnt      <= (state_nx != state_q) ? '0 : cnt + CNT_SW'(1);
      drain    <= (state_q == S_MON_MONITOR) && (state_nx == S_MON_MONITOR) && (finish || drain);
      s1_valid <= write_ok && in_region;
      s1_idx   <= idx;
      s1_addr  <= SRAM_address;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      sw_rd_q  <= ram_rd_en && (state_q == S_MON_SWEEP);

      if (state_nx == S_MON_CLEAR && state_q != S_MON_CLEAR) begin
        oor_count        <= '0;
        multi_count      <= '0;
        unwritten_count  <= '0;
        first_multi_addr <= '0;
        signature        <= CRC_INIT;
      end

      if (write_ok) begin
        if (in_region) signature <= sig_nx;
        else if (oor_count != '1) oor_count <= oor_count + CNT_W'(1);
      end

      if (state_q == S_MON_MONITOR && s1_valid && seen) begin
        if (multi_count == '0) first_multi_addr <= s1_addr;
        if (multi_count != '1) multi_count <= multi_count + CNT_W'(1);
      end

      if (sw_rd_q && !ram_rd_data && unwritten_count != '1)
        unwritten_count <= unwritten_count + CNT_W'(1);
    end
  end

  write_bitmap_ram #(.DEPTH(DEPTH), .AW(IDX_W)) u_bitmap (
    .clk     (Clock_50),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_sram_write_monitor.sv
// tb/tb_sram_write_monitor.sv - directed self-checking bench for sram_write_monitor (region 16..31)
module tb_sram_write_monitor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, finish, start3, finish3, we_n;
  logic [7:0]  addr;
  logic [15:0] wdata;

  logic        busy, done, busy3, done3;
  logic [17:0] oor, multi, unw;
  logic [2:0]  oor3, multi3, unw3;
  logic [7:0]  first, first3;
  logic [15:0] sig, sig3;

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [15:0] exp_sig, sig_full;

  sram_write_monitor #(.ADDR_W(8), .DATA_W(16), .REGION_LO(16), .REGION_HI(31), .CNT_W(18)) dut (
    .Clock_50(clk), .Reset(rst), .start(start), .finish(finish), .SRAM_we_n(we_n),
    .SRAM_address(addr), .SRAM_write_data(wdata), .busy(busy), .done(done),
    .oor_count(oor), .multi_count(multi), .unwritten_count(unw),
    .first_multi_addr(first), .signature(sig)
  );

  sram_write_monitor #(.ADDR_W(8), .DATA_W(16), .REGION_LO(16), .REGION_HI(31), .CNT_W(3)) dut3 (
    .Clock_50(clk), .Reset(rst), .start(start3), .finish(finish3), .SRAM_we_n(we_n),
    .SRAM_address(addr), .SRAM_write_data(wdata), .busy(busy3), .done(done3),
    .oor_count(oor3), .multi_count(multi3), .unwritten_count(unw3),
    .first_multi_addr(first3), .signature(sig3)
  );

  // Reference CRC: xor the word into the register, then 16 plain shifts.
  function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc ^ d;
    for (int i = 0; i < 16; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a);
    we_n  = 1'b0;
    addr  = a;
    wdata = {8'h00, a};
    if (a >= 8'd16 && a <= 8'd31) exp_sig = crc_ref(exp_sig, {8'h00, a});
    step();
    we_n  = 1'b1;
  endtask

  task automatic fill(input logic [7:0] lo, input logic [7:0] hi);
    for (int a = lo; a <= hi; a++) wr(8'(a));
  endtask

  task automatic do_start(output int clr);
    start   = 1'b1;
    exp_sig = 16'hFFFF;
    step();
    start = 1'b0;
    clr   = 0;
    while (busy && clr < 40) begin
      clr++;
      step();
    end
    check("clear_ends", 32'(busy), 32'd0);
  endtask

  task automatic do_finish(output int sw);
    finish = 1'b1;
    step();
    finish = 1'b0;
    sw     = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (busy) sw++;
      step();
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_oor"},   32'(oor),   32'd0);
    check({tag, "_multi"}, 32'(multi), 32'd0);
    check({tag, "_unw"},   32'(unw),   32'd0);
    check({tag, "_first"}, 32'(first), 32'd0);
    check({tag, "_sig"},   32'(sig),   32'hFFFF);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; start3 = 1'b0; finish3 = 1'b0;
    we_n = 1'b1; addr = '0; wdata = '0; exp_sig = 16'hFFFF;
    step(); step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");
    check("reset_sig3", 32'(sig3), 32'hFFFF);

    // Test 1: full fill, sweep latency
    do_start(n);
    check("t1_clear_cycles", 32'(n), 32'd16);
    fill(16, 31);
    do_finish(n);
    check("t1_sweep_cycles", 32'(n), 32'd18);
    check("t1_unw",   32'(unw),   32'd0);
    check("t1_multi", 32'(multi), 32'd0);
    check("t1_oor",   32'(oor),   32'd0);
    check("t1_sig",   32'(sig),   32'(exp_sig));
    sig_full = exp_sig;
    step(); step();
    check("t1_hold_done", 32'(done), 32'd1);
    check("t1_hold_sig",  32'(sig),  32'(sig_full));

    // Test 2: two words left unwritten
    do_start(n);
    fill(16, 29);
    do_finish(n);
    check("t2_unw",   32'(unw),   32'd2);
    check("t2_multi", 32'(multi), 32'd0);
    check("t2_sig",   32'(sig),   32'(exp_sig));

    // Test 3: back-to-back repeat and gapped repeat
    do_start(n);
    wr(20); wr(20); wr(25);
    step();
    wr(25);
    do_finish(n);
    check("t3_multi", 32'(multi), 32'd2);
    check("t3_first", 32'(first), 32'd20);
    check("t3_unw",   32'(unw),   32'd14);
    check("t3_oor",   32'(oor),   32'd0);
    check("t3_sig",   32'(sig),   32'(exp_sig));

    // Test 4: out-of-region writes do not disturb the signature
    do_start(n);
    wr(5);
    fill(16, 31);
    wr(40);
    do_finish(n);
    check("t4_oor",   32'(oor),   32'd2);
    check("t4_sig",   32'(sig),   32'(sig_full));
    check("t4_unw",   32'(unw),   32'd0);
    check("t4_multi", 32'(multi), 32'd0);

    // Test 5: reset mid-sweep, then the bitmap must be re-cleared
    do_start(n);
    fill(24, 31);
    finish = 1'b1;
    step();
    finish = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t5_in_sweep", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check_reset_outputs("t5_reset");
    rst = 1'b0;
    do_start(n);
    fill(16, 31);
    do_finish(n);
    check("t5_unw",   32'(unw),   32'd0);
    check("t5_multi", 32'(multi), 32'd0);
    check("t5_sig",   32'(sig),   32'(sig_full));

    // Test 6: 3-bit counters saturate; stray start/finish ignored
    finish3 = 1'b1;
    step();
    finish3 = 1'b0;
    step();
    check("t6_finish_idle_busy", 32'(busy3), 32'd0);
    check("t6_finish_idle_done", 32'(done3), 32'd0);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    n = 0;
    while (busy3 && n < 40) begin
      n++;
      step();
    end
    check("t6_clear_cycles", 32'(n), 32'd16);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    check("t6_start_mon_busy", 32'(busy3), 32'd0);
    for (int i = 0; i < 9; i++) wr(8'd5);
    check("t6_oor_sat", 32'(oor3), 32'd7);
    finish3 = 1'b1;
    step();
    finish3 = 1'b0;
    for (int i = 0; i < 100 && !done3; i++) step();
    check("t6_done",    32'(done3), 32'd1);
    check("t6_oor",     32'(oor3),  32'd7);
    check("t6_unw_sat", 32'(unw3),  32'd7);
    check("t6_main_oor_untouched", 32'(oor), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
